// File: rtl/noc_output_port_arbiter.sv
// Output-port scheduler: round-robin arbitration among NUM_REQ inputs with wormhole
// packet locking, credit-based flow control and saturating stall/grant telemetry.
module noc_output_port_arbiter #(
  parameter int NUM_REQ    = 5,
  parameter int FLIT_WIDTH = 64,
  parameter int CREDITS    = 4,
  parameter int CTR_W      = 32,
  localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CL_W      = $clog2(CREDITS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
  output logic [NUM_REQ-1:0]            grant,
  output logic [FLIT_WIDTH-1:0]         flit_out,
  output logic                          valid_out,
  input  logic                          credit_return,
  input  logic                          clr_stats,
  output logic [CL_W-1:0]               credit_level,
  output logic                          locked,
  output logic [PTR_W-1:0]              lock_owner,
  output logic [CTR_W-1:0]              grant_count,
  output logic [CTR_W-1:0]              stall_arb_count,
  output logic [CTR_W-1:0]              stall_bp_count,
  output logic                          credit_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b11;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        owner_nxt;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        win_p0;
  logic [PTR_W-1:0]        idx;
  logic                    win_vld_p0;
  logic [FLIT_WIDTH-1:0]   flit_p0;
  logic [1:0]              ftype_p0;
  logic [NUM_REQ-1:0]      elig_p0;

  function automatic logic [PTR_W:0] popcount(input logic [NUM_REQ-1:0] v);
    logic [PTR_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_REQ; i++) n = n + {{PTR_W{1'b0}}, v[i]};
    return n;
  endfunction

  function automatic logic [CTR_W-1:0] sat_add(input logic [CTR_W-1:0] c, input logic [PTR_W:0] inc);
    logic [CTR_W:0] s;
    s = {1'b0, c} + {{(CTR_W-PTR_W){1'b0}}, inc};
    return s[CTR_W] ? {CTR_W{1'b1}} : s[CTR_W-1:0];
  endfunction

  // Stage p0: combinational arbitration and grant
  always_comb begin
    win_p0     = '0;
    win_vld_p0 = 1'b0;
    idx        = '0;
    grant      = '0;
    if (credit_level != '0) begin
      if (state == LOCKED) begin
        win_p0     = lock_owner;
        win_vld_p0 = req[lock_owner];
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
          if (!win_vld_p0 && req[idx]) begin
            win_vld_p0 = 1'b1;
            win_p0     = idx;
          end
        end
      end
    end
    if (win_vld_p0) grant[win_p0] = 1'b1;
  end

  assign flit_p0  = req_flit[win_p0*FLIT_WIDTH +: FLIT_WIDTH];
  assign ftype_p0 = flit_p0[47:46];

  // Backpressure stalls only charge requesters that could have been served.
  always_comb begin
    elig_p0 = req;
    if (state == LOCKED) begin
      elig_p0             = '0;
      elig_p0[lock_owner] = req[lock_owner];
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = lock_owner;
    if (win_vld_p0) begin
      case (state)
        IDLE:    if (ftype_p0 == FT_HEAD) begin
                   state_nxt = LOCKED;
                   owner_nxt = win_p0;
                 end
        LOCKED:  if (ftype_p0 == FT_TAIL) state_nxt = IDLE;
        default: ;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lock_owner <= '0;
      rr_ptr     <= PTR_W'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      lock_owner <= owner_nxt;
      if (win_vld_p0) rr_ptr <= win_p0;
    end
  end

  // Stage p1: registered link outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      flit_out  <= '0;
    end else begin
      valid_out <= win_vld_p0;
      if (win_vld_p0) flit_out <= flit_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_level <= CL_W'(CREDITS);
      credit_err   <= 1'b0;
    end else if (win_vld_p0 && !credit_return) begin
      credit_level <= credit_level - CL_W'(1);
    end else if (!win_vld_p0 && credit_return) begin
      if (credit_level == CL_W'(CREDITS)) credit_err   <= 1'b1;
      else                                credit_level <= credit_level + CL_W'(1);
    end
  end

  // Losers to a foreign lock still count as arbitration stalls when credits exist.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_count     <= '0;
      stall_arb_count <= '0;
      stall_bp_count  <= '0;
    end else if (clr_stats) begin
      grant_count     <= '0;
      stall_arb_count <= '0;
      stall_bp_count  <= '0;
    end else begin
      grant_count <= sat_add(grant_count, {{PTR_W{1'b0}}, win_vld_p0});
      if (credit_level == '0) stall_bp_count  <= sat_add(stall_bp_count, popcount(elig_p0));
      else                    stall_arb_count <= sat_add(stall_arb_count, popcount(req & ~grant));
    end
  end

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Scoreboard bench for noc_output_port_arbiter: directed scenarios plus random traffic
// checked against a behavioural model of the arbitration, credit and telemetry rules.
module tb_noc_output_port_arbiter;

  localparam int N  = 5;
  localparam int FW = 64;
  localparam int CR = 4;
  localparam int CW = 32;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*FW-1:0] req_flit = '0;
  logic [N-1:0]    grant;
  logic [FW-1:0]   flit_out;
  logic            valid_out;
  logic            credit_return = 1'b0;
  logic            clr_stats = 1'b0;
  logic [2:0]      credit_level;
  logic            locked;
  logic [2:0]      lock_owner;
  logic [CW-1:0]   grant_count, stall_arb_count, stall_bp_count;
  logic            credit_err;

  noc_output_port_arbiter #(.NUM_REQ(N), .FLIT_WIDTH(FW), .CREDITS(CR), .CTR_W(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_flit(req_flit), .grant(grant),
    .flit_out(flit_out), .valid_out(valid_out), .credit_return(credit_return),
    .clr_stats(clr_stats), .credit_level(credit_level), .locked(locked),
    .lock_owner(lock_owner), .grant_count(grant_count), .stall_arb_count(stall_arb_count),
    .stall_bp_count(stall_bp_count), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [63:0] sb_q[$];

  int          m_cred, m_owner, m_rr;
  bit          m_locked, m_err, m_valid;
  logic [63:0] m_flit;
  longint      m_gc, m_arb, m_bp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic logic [63:0] mkflit(input logic [1:0] ty);
    logic [63:0] f;
    f = {$urandom, $urandom};
    f[47:46] = ty;
    return f;
  endfunction

  function automatic logic [2*N-1:0] ty5(input logic [1:0] n, s, e, w, l);
    return {l, w, e, s, n};
  endfunction

  task automatic model_reset();
    m_cred = CR; m_owner = 0; m_rr = N - 1;
    m_locked = 0; m_err = 0; m_valid = 0; m_flit = '0;
    m_gc = 0; m_arb = 0; m_bp = 0;
    sb_q.delete();
  endtask

  task automatic check_regs();
    chk("valid_out", 64'(valid_out), 64'(m_valid));
    chk("flit_out", flit_out, m_flit);
    chk("credit_level", 64'(credit_level), 64'(m_cred));
    chk("locked", 64'(locked), 64'(m_locked));
    chk("lock_owner", 64'(lock_owner), 64'(m_owner));
    chk("grant_count", 64'(grant_count), 64'(m_gc));
    chk("stall_arb_count", 64'(stall_arb_count), 64'(m_arb));
    chk("stall_bp_count", 64'(stall_bp_count), 64'(m_bp));
    chk("credit_err", 64'(credit_err), 64'(m_err));
  endtask

  // One clock of stimulus; the model advances to the state after the coming posedge.
  task automatic cycle(input logic [N-1:0] r, input logic [2*N-1:0] tys, input logic cr, input logic clr);
    int g;
    int eln;
    logic [63:0] fl [N];
    logic [1:0] gty;
    @(negedge clk);
    check_regs();
    for (int i = 0; i < N; i++) begin
      fl[i] = mkflit(tys[2*i +: 2]);
      req_flit[i*FW +: FW] = fl[i];
    end
    req = r; credit_return = cr; clr_stats = clr;
    #1;
    g = -1;
    if (m_cred > 0) begin
      if (m_locked) begin
        if (r[m_owner]) g = m_owner;
      end else begin
        for (int k = 1; k <= N; k++)
          if (g < 0 && r[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    chk("grant", 64'(grant), (g >= 0) ? (64'd1 << g) : 64'd0);
    if (clr) begin
      m_gc = 0; m_arb = 0; m_bp = 0;
    end else begin
      m_gc = sat(m_gc + ((g >= 0) ? 1 : 0));
      if (m_cred == 0) begin
        eln  = m_locked ? int'(r[m_owner]) : $countones(r);
        m_bp = sat(m_bp + eln);
      end else begin
        m_arb = sat(m_arb + $countones(r) - ((g >= 0) ? 1 : 0));
      end
    end
    if (g >= 0 && !cr) m_cred--;
    else if (g < 0 && cr) begin
      if (m_cred == CR) m_err = 1;
      else m_cred++;
    end
    m_valid = (g >= 0);
    if (g >= 0) begin
      m_flit = fl[g];
      sb_q.push_back(fl[g]);
      gty = tys[2*g +: 2];
      m_rr = g;
      if (!m_locked && gty == 2'b01) begin
        m_locked = 1; m_owner = g;
      end else if (m_locked && gty == 2'b11) begin
        m_locked = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; credit_return = 0; clr_stats = 0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_regs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every presented flit must match the oldest granted one.
  initial begin
    logic [63:0] exp;
    forever begin
      @(posedge clk);
      #2;
      if (!reset && valid_out) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected: got flit=%0h with no grant outstanding", flit_out);
        end else begin
          exp = sb_q.pop_front();
          chk("sb_flit", flit_out, exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    cycle(5'b00011, '0, 0, 0);
    cycle(5'b00010, '0, 0, 0);
    cycle('0, '0, 0, 0);
    chk("t1_grant_count", 64'(grant_count), 64'd2);
    chk("t1_stall_arb", 64'(stall_arb_count), 64'd1);

    do_reset();
    repeat (6) cycle(5'b11111, '0, 1, 0);
    cycle('0, '0, 0, 0);
    chk("t2_grant_count", 64'(grant_count), 64'd6);
    chk("t2_stall_bp", 64'(stall_bp_count), 64'd0);

    do_reset();
    cycle(5'b00100, '0, 1, 0);
    cycle(5'b01001, ty5(2'b00, 2'b00, 2'b00, 2'b01, 2'b00), 1, 0);
    cycle(5'b01001, ty5(2'b00, 2'b00, 2'b00, 2'b10, 2'b00), 1, 0);
    cycle(5'b01001, ty5(2'b00, 2'b00, 2'b00, 2'b11, 2'b00), 1, 0);
    cycle(5'b00001, '0, 1, 0);
    cycle('0, '0, 0, 0);
    chk("t3_stall_arb", 64'(stall_arb_count), 64'd3);
    chk("t3_locked_after", 64'(locked), 64'd0);

    do_reset();
    repeat (4) cycle(5'b00001, '0, 0, 0);
    repeat (3) cycle(5'b00001, '0, 0, 0);
    cycle('0, '0, 0, 0);
    chk("t4_stall_bp", 64'(stall_bp_count), 64'd3);
    chk("t4_credit_zero", 64'(credit_level), 64'd0);
    cycle('0, '0, 1, 0);
    cycle(5'b00001, '0, 0, 0);
    cycle('0, '0, 0, 0);
    chk("t4_grant_count", 64'(grant_count), 64'd5);

    do_reset();
    cycle(5'b00001, '0, 1, 0);
    cycle('0, '0, 1, 0);
    cycle('0, '0, 0, 0);
    chk("t5_credit_err", 64'(credit_err), 64'd1);
    chk("t5_credit_level", 64'(credit_level), 64'd4);

    do_reset();
    cycle(5'b01000, ty5(2'b00, 2'b00, 2'b00, 2'b01, 2'b00), 0, 0);
    cycle(5'b01000, ty5(2'b00, 2'b00, 2'b00, 2'b10, 2'b00), 0, 0);
    cycle(5'b01000, ty5(2'b00, 2'b00, 2'b00, 2'b10, 2'b00), 0, 0);
    @(negedge clk);
    check_regs();
    chk("t6_pre_locked", 64'(locked), 64'd1);
    chk("t6_pre_credit", 64'(credit_level), 64'd1);
    req = '0; credit_return = 0; clr_stats = 0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("t6_async_valid", 64'(valid_out), 64'd0);
    chk("t6_async_locked", 64'(locked), 64'd0);
    chk("t6_async_credit", 64'(credit_level), 64'd4);
    check_regs();
    @(negedge clk);
    reset = 1'b0;

    repeat (400) cycle(5'($urandom), 10'($urandom), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 39) == 0));

    cycle(5'b11111, '0, 0, 1);
    cycle('0, '0, 0, 0);
    chk("clr_grant_count", 64'(grant_count), 64'd0);
    chk("clr_stall_arb", 64'(stall_arb_count), 64'd0);
    chk("clr_stall_bp", 64'(stall_bp_count), 64'd0);

    repeat (2) cycle('0, '0, 0, 0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
